// File: rtl/crc8_frame_ctrl.sv
// Transmit framing controller: forwards payload bytes and appends the CRC-8
// trailer produced by the external engine. Overlong frames are cut at MAX_LEN.
module crc8_frame_ctrl #(
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             crc_init,
    output logic             crc_data_valid,
    output logic [7:0]       crc_data,
    input  logic [7:0]       crc_in,
    output logic             busy,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_DATA, S_DROP, S_CRC, S_TAIL
    } state_t;

    localparam logic [7:0] MaxB = 8'(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ov_q, ov_d;
    logic [7:0]       od_q, od_d;
    logic             ol_q, ol_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             slot_free;

    assign slot_free   = !ov_q || out_ready;
    assign crc_data    = in_data;
    assign out_valid   = ov_q;
    assign out_data    = od_q;
    assign out_last    = ol_q;
    assign frame_err   = err_q;
    assign frame_count = fcnt_q;
    assign busy        = (state_q != S_IDLE);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ov_d           = ov_q && !out_ready;
        od_d           = od_q;
        ol_d           = ol_q;
        err_d          = 1'b0;
        fcnt_d         = fcnt_q;
        in_ready       = 1'b0;
        crc_init       = 1'b0;
        crc_data_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) state_d = S_INIT;
            end
            S_INIT: begin
                crc_init = 1'b1;
                cnt_d    = '0;
                state_d  = S_DATA;
            end
            S_DATA: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    crc_data_valid = 1'b1;
                    ov_d  = 1'b1;
                    od_d  = in_data;
                    ol_d  = 1'b0;
                    cnt_d = cnt_q + 8'd1;
                    if (in_last) begin
                        state_d = S_CRC;
                    end else if (cnt_d == MaxB) begin
                        err_d   = 1'b1;
                        state_d = S_DROP;
                    end
                end
            end
            // Excess bytes are swallowed so the source can finish its frame.
            S_DROP: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_d = S_CRC;
            end
            S_CRC: begin
                if (slot_free) begin
                    ov_d    = 1'b1;
                    od_d    = crc_in;
                    ol_d    = 1'b1;
                    state_d = S_TAIL;
                end
            end
            S_TAIL: begin
                if (ov_q && out_ready) begin
                    fcnt_d  = fcnt_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule
